spi_regbank: RTL and testbench
==============================

// Module: spi_regbank
// PURPOSE
//  System-clock register bank behind the SPI slave. Consumes its odata/oaddr/wrstb/rdstb and returns idata.
//  Strobes are synchronized into CLK, control registers are written, and sticky status bits are read-to-clear.
//  Provides a read-only ID register at a fixed address.
// PARAMETERS
//  NREGS        8      number of R/W control registers, addresses 0x00..NREGS-1 (NREGS <= 0xF0)
//  CTRL_RST     8'h00  reset value of every control register
//  ID_VALUE     8'hA5  value returned at ID_ADDR
//  SYNC_STAGES  2      flip-flop stages in each strobe synchronizer (>= 2)
// PORTS
//  CLK        in   1         system clock; must be at least 8x the SCK frequency
//  RSTB       in   1         asynchronous active-low reset
//  wrstb      in   1         write strobe, SCK domain (async to CLK)
//  rdstb      in   1         read strobe, SCK domain (async to CLK)
//  odata      in   8         write data, SCK domain
//  oaddr      in   8         register address, SCK domain
//  idata      out  8         read data, combinational decode of oaddr
//  ctrl_out   out  8*NREGS   control registers, register k is ctrl_out[8k+7:8k]
//  status_in  in   8         hardware event pulses (CLK domain) that set the status bits
//  wr_pulse   out  1         one-CLK pulse for each accepted write
//  wr_addr    out  8         address of the last write, held between writes
// BEHAVIOUR
//  Reset (RSTB=0, async): ctrl=CTRL_RST, status=0, wr_pulse=0, wr_addr=0, sync chains=0, irq=0.
//  Strobe sync: each strobe passes through a SYNC_STAGES FF chain plus one edge-detect FF.
//   - wr_rise is asserted SYNC_STAGES..SYNC_STAGES+1 CLK after wrstb rises.
//   - The CLK ratio guarantees odata/oaddr are stable in that cycle; both are sampled directly then.
//  Write, on wr_rise:
//   - oaddr < NREGS: ctrl[oaddr] <= odata.
//   - oaddr == STATUS_ADDR (8'hFE): write-1-to-clear, status <= status & ~odata.
//   - ID_ADDR (8'hFF) and unmapped addresses: no effect on any register.
//   - For every address: wr_pulse=1 for one cycle and wr_addr <= oaddr, in the cycle after wr_rise.
//  Read:
//   - idata = ctrl[oaddr] / status / ID_VALUE / 8'h00 (unmapped), combinational from oaddr.
//   - idata is stable before the slave loads it on the SCK negedge.
//  Read-to-clear status:
//   - On rd_rise: latch rd_hit = (oaddr == STATUS_ADDR) and clr_mask <= status.
//   - On rd_fall (after the slave has loaded idata): if rd_hit, status <= status & ~clr_mask.
//   - rd_hit and clr_mask are then cleared.
//  Status set: status <= status | status_in every cycle.
//   - Set wins over a W1C or read-clear in the same cycle.
//   - A bit set after clr_mask was taken survives the clear.
//  CSB mid-transaction: the slave drops its strobes asynchronously, which only appears here as a falling edge.
//   - A falling edge with no preceding detected rise does nothing.
//   - A strobe shorter than SYNC_STAGES CLK may be lost; this is legal only when the CLK ratio is violated.
//  wr_rise and rd_fall in the same cycle: both take effect. Merge order is W1C, then read-clear, then set.
// CONFIGURATION
//  SPI_REGBANK_IRQ_EN defined:
//   - Adds port irq (out, 1), registered: irq <= |(status & irq_mask).
//   - Adds R/W irq_mask at MASK_ADDR (8'hFD), reset 8'h00.
//  SPI_REGBANK_IRQ_EN undefined:
//   - No irq port and no mask register.
//   - MASK_ADDR reads 8'h00; writes to it only produce wr_pulse.
// STRUCTURE
//  Package spi_regbank_pkg holds:
//   - STATUS_ADDR, MASK_ADDR, ID_ADDR constants
//   - default ID_VALUE and SYNC_STAGES
//   - address-decode enum {DEC_CTRL, DEC_STATUS, DEC_MASK, DEC_ID, DEC_NONE}
//  Sub-module spi_strobe_sync: SYNC_STAGES synchronizer plus edge detect, outputs rise/fall pulses.
//   - Instantiated once for wrstb and once for rdstb.
// TESTING
//  1. Hold RSTB low. -> ctrl_out=all CTRL_RST, idata@0xFF=8'hA5, idata@0xFE=0, wr_pulse=0.
//  2. CLK=8xSCK; SPI write 0x5C to addr 0x03. -> ctrl[3]=0x5C, wr_pulse once, wr_addr=0x03, other ctrl unchanged.
//  3. Pulse status_in=0x81, then SPI read of 0xFE. -> slave shifts out 0x81; status=0 after rd_fall.
//  4. Pulse status_in bit0 in the same CLK as rd_fall of a status read. -> bit0 remains set.
//  5. Write 0x55 to 0xFF and 0x77 to 0x40 (NREGS=8). -> ID still 0xA5, ctrl unchanged, two wr_pulse.
//  6. Define IRQ_EN; write mask 0x02; pulse status_in=0x02. -> irq=1 next cycle; W1C 0x02 -> irq=0.

Source files
------------

// File: rtl/spi_regbank_pkg.sv
// Shared constants, address-decode type and decode helper for the SPI register bank.
package spi_regbank_pkg;

  localparam logic [7:0] STATUS_ADDR = 8'hFE;
  localparam logic [7:0] MASK_ADDR   = 8'hFD;
  localparam logic [7:0] ID_ADDR     = 8'hFF;

  localparam logic [7:0]  ID_VALUE_DEF    = 8'hA5;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DATA_W          = 8;

  typedef enum logic [2:0] {
    DEC_CTRL,
    DEC_STATUS,
    DEC_MASK,
    DEC_ID,
    DEC_NONE
  } dec_e;

  // Control registers occupy 0..nregs-1; nregs never reaches the fixed addresses.
  function automatic dec_e decode(input logic [7:0] addr, input int unsigned nregs);
    dec_e d;
    if (32'(addr) < nregs)       d = DEC_CTRL;
    else if (addr == STATUS_ADDR) d = DEC_STATUS;
    else if (addr == MASK_ADDR)   d = DEC_MASK;
    else if (addr == ID_ADDR)     d = DEC_ID;
    else                          d = DEC_NONE;
    return d;
  endfunction

endpackage

// File: rtl/spi_strobe_sync.sv
// Strobe synchronizer: STAGES-deep FF chain into CLK plus one edge-detect FF.
// Ports:
//   CLK, RSTB      system clock, async active-low reset
//   strobe         asynchronous level strobe from the SCK domain
//   rise_c/fall_c  one-CLK pulses on the synchronized rising/falling edge
module spi_strobe_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic CLK,
  input  logic RSTB,
  input  logic strobe,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] sync_q;
  logic              edge_q;

  // Synchronizer chain and previous-value FF for edge detection
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], strobe};
      edge_q <= sync_q[STAGES-1];
    end
  end

  // A fall with no preceding rise cannot occur: edge_q only goes high after a rise
  assign rise_c =  sync_q[STAGES-1] & ~edge_q;
  assign fall_c = ~sync_q[STAGES-1] &  edge_q;

endmodule

// File: rtl/spi_regbank.sv
// System-clock register bank behind the SPI slave.
// Control registers (R/W), sticky status (W1C and read-to-clear), fixed ID register.
// Optional feature macro: SPI_REGBANK_IRQ_EN adds irq output and irq_mask register.
// Ports:
//   CLK, RSTB        system clock, async active-low reset
//   wrstb, rdstb     write/read strobes from the SCK domain
//   odata, oaddr     write data and address from the slave (stable around strobe edges)
//   idata            read data, combinational decode of oaddr
//   ctrl_out         control registers, register k at [8k+7:8k]
//   status_in        CLK-domain event pulses that set status bits
//   wr_pulse         one-CLK pulse per accepted write
//   wr_addr          address of the last write
//   irq              (SPI_REGBANK_IRQ_EN only) |(status & irq_mask), registered
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int unsigned NREGS       = 8,
  parameter logic [7:0]  CTRL_RST    = 8'h00,
  parameter logic [7:0]  ID_VALUE    = ID_VALUE_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  CLK,
  input  logic                  RSTB,
  input  logic                  wrstb,
  input  logic                  rdstb,
  input  logic [DATA_W-1:0]     odata,
  input  logic [DATA_W-1:0]     oaddr,
  output logic [DATA_W-1:0]     idata,
  output logic [DATA_W*NREGS-1:0] ctrl_out,
  input  logic [DATA_W-1:0]     status_in,
`ifdef SPI_REGBANK_IRQ_EN
  output logic                  irq,
`endif
  output logic                  wr_pulse,
  output logic [DATA_W-1:0]     wr_addr
);

  logic              wr_rise;
  logic              wr_fall;
  logic              rd_rise;
  logic              rd_fall;
  dec_e              dec;
  logic [DATA_W-1:0] status_q;
  logic [DATA_W-1:0] status_nxt;
  logic [DATA_W-1:0] clr_mask;
  logic              rd_hit;
`ifdef SPI_REGBANK_IRQ_EN
  logic [DATA_W-1:0] irq_mask;
`endif

  spi_strobe_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .CLK    (CLK),
    .RSTB   (RSTB),
    .strobe (wrstb),
    .rise_c (wr_rise),
    .fall_c (wr_fall)
  );

  spi_strobe_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .CLK    (CLK),
    .RSTB   (RSTB),
    .strobe (rdstb),
    .rise_c (rd_rise),
    .fall_c (rd_fall)
  );

  // Write side only acts on rising edges; the falling edge is deliberately ignored
  logic unused_wr_fall;
  assign unused_wr_fall = wr_fall;

  assign dec = decode(oaddr, NREGS);

  // Status merge: W1C, then read-clear, then set (set always wins)
  always_comb begin
    status_nxt = status_q;
    if (wr_rise && (dec == DEC_STATUS)) status_nxt = status_nxt & ~odata;
    if (rd_fall && rd_hit)              status_nxt = status_nxt & ~clr_mask;
    status_nxt = status_nxt | status_in;
  end

  // Read mux
  always_comb begin
    idata = 8'h00;
    unique case (dec)
      DEC_CTRL: begin
        for (int unsigned k = 0; k < NREGS; k++) begin
          if (oaddr == 8'(k)) idata = ctrl_out[DATA_W*k +: DATA_W];
        end
      end
      DEC_STATUS: idata = status_q;
`ifdef SPI_REGBANK_IRQ_EN
      DEC_MASK:   idata = irq_mask;
`else
      DEC_MASK:   idata = 8'h00;
`endif
      DEC_ID:     idata = ID_VALUE;
      default:    idata = 8'h00;
    endcase
  end

  // Register state
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      ctrl_out <= {NREGS{CTRL_RST}};
      status_q <= '0;
      clr_mask <= '0;
      rd_hit   <= 1'b0;
      wr_pulse <= 1'b0;
      wr_addr  <= '0;
    end else begin
      status_q <= status_nxt;
      wr_pulse <= wr_rise;
      if (wr_rise) wr_addr <= oaddr;
      for (int unsigned k = 0; k < NREGS; k++) begin
        if (wr_rise && (dec == DEC_CTRL) && (oaddr == 8'(k)))
          ctrl_out[DATA_W*k +: DATA_W] <= odata;
      end
      // Snapshot on rise so bits set during the read survive the clear
      if (rd_rise) begin
        rd_hit   <= (oaddr == STATUS_ADDR);
        clr_mask <= status_q;
      end else if (rd_fall) begin
        rd_hit   <= 1'b0;
        clr_mask <= '0;
      end
    end
  end

`ifdef SPI_REGBANK_IRQ_EN
  // Interrupt mask register and registered interrupt output
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (wr_rise && (dec == DEC_MASK)) irq_mask <= odata;
      irq <= |(status_q & irq_mask);
    end
  end
`endif

endmodule

// File: tb/tb_spi_regbank.sv
// Directed self-checking bench for spi_regbank (NREGS=8, CTRL_RST=0, ID=A5, 2 sync stages).
module tb_spi_regbank;

  logic        CLK;
  logic        RSTB;
  logic        wrstb;
  logic        rdstb;
  logic [7:0]  odata;
  logic [7:0]  oaddr;
  logic [7:0]  idata;
  logic [63:0] ctrl_out;
  logic [7:0]  status_in;
  logic        wr_pulse;
  logic [7:0]  wr_addr;
`ifdef SPI_REGBANK_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  spi_regbank dut (
    .CLK       (CLK),
    .RSTB      (RSTB),
    .wrstb     (wrstb),
    .rdstb     (rdstb),
    .odata     (odata),
    .oaddr     (oaddr),
    .idata     (idata),
    .ctrl_out  (ctrl_out),
    .status_in (status_in),
`ifdef SPI_REGBANK_IRQ_EN
    .irq       (irq),
`endif
    .wr_pulse  (wr_pulse),
    .wr_addr   (wr_addr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Count CLK cycles in which wr_pulse is high
  always @(posedge CLK) if (wr_pulse) pulse_cnt = pulse_cnt + 1;

  // SPI-like write: strobe high for half an SCK period (CLK = 8x SCK)
  task automatic spi_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge CLK);
    oaddr = a; odata = d; wrstb = 1'b1;
    repeat (4) @(negedge CLK);
    wrstb = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  // SPI-like read: idata sampled where the slave would load it
  task automatic spi_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge CLK);
    oaddr = a; rdstb = 1'b1;
    repeat (4) @(negedge CLK);
    d = idata;
    rdstb = 1'b0;
    repeat (6) @(negedge CLK);
  endtask

  task automatic pulse_status(input logic [7:0] v);
    @(negedge CLK); status_in = v;
    @(negedge CLK); status_in = 8'h00;
  endtask

  task automatic peek(input logic [7:0] a, output logic [7:0] d);
    @(negedge CLK); oaddr = a; #1; d = idata;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    RSTB = 1'b0; wrstb = 0; rdstb = 0; odata = 0; status_in = 0;
    oaddr = 8'hFF;
    repeat (3) @(negedge CLK);
    #1;
    n_checks++; if (ctrl_out !== 64'h0) begin n_fail++; $display("FAIL reset_ctrl got %h exp %h", ctrl_out, 64'h0); end
    n_checks++; if (idata !== 8'hA5) begin n_fail++; $display("FAIL reset_id got %h exp a5", idata); end
    n_checks++; if (wr_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wr_pulse got %b exp 0", wr_pulse); end
    n_checks++; if (wr_addr !== 8'h00) begin n_fail++; $display("FAIL reset_wr_addr got %h exp 00", wr_addr); end
    oaddr = 8'hFE; #1;
    n_checks++; if (idata !== 8'h00) begin n_fail++; $display("FAIL reset_status got %h exp 00", idata); end
    @(negedge CLK); RSTB = 1'b1;
    repeat (2) @(negedge CLK);
    peek(8'hFF, v);
    n_checks++; if (v !== 8'hA5) begin n_fail++; $display("FAIL id_after_reset got %h exp a5", v); end
  endtask

  task automatic test_write;
    int c0;
    logic [7:0] v;
    c0 = pulse_cnt;
    spi_write(8'h03, 8'h5C);
    n_checks++; if (ctrl_out !== 64'h0000_0000_5C00_0000) begin n_fail++; $display("FAIL write_ctrl got %h exp 000000005c000000", ctrl_out); end
    n_checks++; if (pulse_cnt - c0 !== 1) begin n_fail++; $display("FAIL write_pulse_count got %0d exp 1", pulse_cnt - c0); end
    n_checks++; if (wr_addr !== 8'h03) begin n_fail++; $display("FAIL write_wr_addr got %h exp 03", wr_addr); end
    spi_write(8'h07, 8'hC3);
    n_checks++; if (ctrl_out !== 64'hC300_0000_5C00_0000) begin n_fail++; $display("FAIL write_ctrl7 got %h exp c30000005c000000", ctrl_out); end
    spi_read(8'h03, v);
    n_checks++; if (v !== 8'h5C) begin n_fail++; $display("FAIL read_ctrl3 got %h exp 5c", v); end
  endtask

  task automatic test_status_read;
    logic [7:0] v;
    pulse_status(8'h81);
    @(negedge CLK);
    spi_read(8'hFE, v);
    n_checks++; if (v !== 8'h81) begin n_fail++; $display("FAIL status_read_data got %h exp 81", v); end
    peek(8'hFE, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL status_after_rc got %h exp 00", v); end
  endtask

  task automatic test_set_wins;
    logic [7:0] v;
    pulse_status(8'h11);
    @(negedge CLK);
    oaddr = 8'hFE; rdstb = 1'b1;
    repeat (4) @(negedge CLK);
    v = idata;
    n_checks++; if (v !== 8'h11) begin n_fail++; $display("FAIL set_wins_read got %h exp 11", v); end
    rdstb = 1'b0;
    // rd_fall is active during the second cycle after the drop
    @(negedge CLK);
    @(negedge CLK); status_in = 8'h01;
    @(negedge CLK); status_in = 8'h00;
    repeat (3) @(negedge CLK);
    peek(8'hFE, v);
    n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL set_wins_status got %h exp 01", v); end
    // Non-status read must not clear status
    spi_read(8'h02, v);
    peek(8'hFE, v);
    n_checks++; if (v !== 8'h01) begin n_fail++; $display("FAIL other_read_keeps got %h exp 01", v); end
  endtask

  task automatic test_w1c;
    logic [7:0] v;
    pulse_status(8'h06);
    peek(8'hFE, v);
    n_checks++; if (v !== 8'h07) begin n_fail++; $display("FAIL w1c_pre got %h exp 07", v); end
    spi_write(8'hFE, 8'h05);
    peek(8'hFE, v);
    n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL w1c_post got %h exp 02", v); end
    spi_write(8'hFE, 8'h02);
  endtask

  task automatic test_unmapped;
    int c0;
    logic [7:0] v;
    c0 = pulse_cnt;
    spi_write(8'hFF, 8'h55);
    spi_write(8'h40, 8'h77);
    n_checks++; if (pulse_cnt - c0 !== 2) begin n_fail++; $display("FAIL unmapped_pulses got %0d exp 2", pulse_cnt - c0); end
    n_checks++; if (ctrl_out !== 64'hC300_0000_5C00_0000) begin n_fail++; $display("FAIL unmapped_ctrl got %h exp c30000005c000000", ctrl_out); end
    n_checks++; if (wr_addr !== 8'h40) begin n_fail++; $display("FAIL unmapped_wr_addr got %h exp 40", wr_addr); end
    peek(8'hFF, v);
    n_checks++; if (v !== 8'hA5) begin n_fail++; $display("FAIL id_after_write got %h exp a5", v); end
    peek(8'h40, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL unmapped_read got %h exp 00", v); end
    peek(8'h08, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL past_nregs_read got %h exp 00", v); end
`ifndef SPI_REGBANK_IRQ_EN
    c0 = pulse_cnt;
    spi_write(8'hFD, 8'h3C);
    peek(8'hFD, v);
    n_checks++; if (v !== 8'h00) begin n_fail++; $display("FAIL mask_absent_read got %h exp 00", v); end
    n_checks++; if (pulse_cnt - c0 !== 1) begin n_fail++; $display("FAIL mask_absent_pulse got %0d exp 1", pulse_cnt - c0); end
`endif
  endtask

`ifdef SPI_REGBANK_IRQ_EN
  task automatic test_irq;
    logic [7:0] v;
    spi_write(8'hFD, 8'h02);
    peek(8'hFD, v);
    n_checks++; if (v !== 8'h02) begin n_fail++; $display("FAIL irq_mask_read got %h exp 02", v); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle got %b exp 0", irq); end
    pulse_status(8'h02);
    @(negedge CLK);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b exp 1", irq); end
    spi_write(8'hFE, 8'h02);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b exp 0", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_status_read();
    test_set_wins();
    test_w1c();
    test_unmapped();
`ifdef SPI_REGBANK_IRQ_EN
    test_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
